vcache_linefetch: RTL
=====================

# vcache_linefetch

Parametrised successor to the VGA line cache. It is a single-clock Wishbone classic read master that prefetches one scanline of framebuffer words per line request into an internal FIFO. It unpacks each 32-bit word into pixels on demand from the timing generator. Compared with the current cache, it adds configurable geometry and pixel depth, backpressure against a full FIFO, bounded retry on `wb_rty_i`, and error substitution. It also provides frame-synchronous flush and sticky underrun/late status flags. It sits between the Wishbone interconnect and the VGA timing/RGB output stage, with both in the `wb_clk_i` domain.

## Interface
Parameters:
- `VRAM_ADR_BASE`, default 'hf80000 — byte address of pixel (0,0).
- `WORDS_PER_LINE`, default 160 — 32-bit words fetched per line.
- `LINES`, default 480 — lines per frame; further line requests are ignored.
- `PIX_W`, default 8 — bits per pixel; legal values are 8, 16, 32; pixels per word `PPW = 32/PIX_W`.
- `FIFO_AW`, default 8 — FIFO depth is `2**FIFO_AW` words.
- `MAX_RETRY`, default 3 — number of `rty` reissues before a word is treated as an error.

Ports:
- `wb_clk_i`  in  1  — the single clock.
- `wb_rst_i`  in  1  — reset, asynchronous, active-low.
- `frame_start_i`  in  1  — one-cycle pulse in vblank; flushes and restarts the frame.
- `line_start_i`  in  1  — one-cycle pulse requesting the next line fetch.
- `pix_rd_i`  in  1  — consume one pixel this cycle.
- `pix_o`  out  PIX_W  — current head pixel; 0 when the FIFO is empty.
- `pix_vld_o`  out  1  — the FIFO is non-empty.
- `wb_cyc_o`, `wb_stb_o`  out  1  — Wishbone cycle and strobe.
- `wb_adr_o`  out  32  — word-aligned read address.
- `wb_we_o`  out  1  — constant 0.
- `wb_sel_o`  out  4  — constant 4'b1111.
- `wb_dat_o`  out  32  — constant 0.
- `wb_dat_i`  in  32  — Wishbone read data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1  — Wishbone terminations.
- `busy_o`  out  1  — high while in the FETCH state.
- `underrun_o`, `late_o`, `err_o`  out  1  — sticky status flags; cleared by `frame_start_i`.

## Operation
- State machine states are IDLE, FETCH and RETRY.
- IDLE → FETCH when `line_start_i` is high and `line_cnt < LINES`. On entry, `word_cnt` is set to 0.
- In FETCH, `cyc` and `stb` are raised only when the FIFO holds fewer than `2**FIFO_AW` words. Once raised, they are held until a termination arrives.
- On `ack`, the word is pushed, `adr` advances by 4 and `word_cnt` increments.
- On `err`, 32'h0 is pushed instead of the data, `err_o` is set, and `adr` and `word_cnt` advance exactly as for `ack`.
- On `rty`, `cyc` and `stb` drop and the state goes to RETRY. RETRY returns to FETCH on the next cycle with the same address, and `retry_cnt` increments. If `retry_cnt` has already reached `MAX_RETRY`, the `rty` is handled as `err` and no retry occurs. `retry_cnt` clears on any `ack` or `err`.
- The termination of word `WORDS_PER_LINE-1` causes FETCH → IDLE, increments `line_cnt`, and drops `cyc`/`stb` the same cycle.
- If `line_start_i` arrives while not in IDLE, `late_o` is set and the request is dropped.
- If `line_start_i` arrives with `line_cnt == LINES`, it is ignored and no flag is set.
- `frame_start_i` has the highest priority. It does the following:
  - aborts any cycle: `cyc`/`stb` are 0 the next cycle and a coincident ack is discarded;
  - empties the FIFO and clears the lane index;
  - sets `line_cnt = 0` and `adr = VRAM_ADR_BASE`;
  - forces the state to IDLE;
  - clears all three sticky flags.
- `wb_adr_o` is a running register equal to `VRAM_ADR_BASE + 4*(line_cnt*WORDS_PER_LINE + word_cnt)`. It is never computed with a multiplier.
- Pixel side: the head word is unpacked LSB-first, so lane k occupies bits `[k*PIX_W +: PIX_W]`.
  - `pix_o` is combinational from the head word and the lane index.
  - `pix_rd_i` with `pix_vld_o` high advances the lane. On lane `PPW-1`, the word is popped and the lane returns to 0.
  - `pix_rd_i` with the FIFO empty sets `underrun_o`; nothing moves and `pix_o` stays 0.
- A simultaneous push and pop leaves the occupancy unchanged. A push into a full FIFO cannot occur, because the `stb` gating prevents it.

## Timing
- Reset values: `cyc`, `stb`, `pix_o`, `pix_vld_o`, `busy_o` and all flags are 0; `wb_adr_o = VRAM_ADR_BASE`; state is IDLE; all counters are 0.
- `line_start_i` at edge N gives `cyc`/`stb` high after edge N (the FIFO is non-full).
- A word acked at edge M is visible on `pix_o`/`pix_vld_o` after edge M, so the latency is 1 cycle.
- `rty` at edge R gives `stb` low for one cycle and high again after R+1, at the same address.
- A zero-wait slave sustains 1 word per cycle, so a 160-word line completes in 160 cycles plus 1 cycle of entry.
- `frame_start_i` at edge F gives `cyc`=0, `pix_vld_o`=0 and flags 0 after F.

## Test plan
- **Single line fill:** reset, then `frame_start`, then `line_start`, with a zero-wait slave returning the address as data. Required: 160 acks at addresses 'hf80000..'hf8027c, then `busy_o` falls. Reading 640 pixels at 8 bpp yields bytes in LSB-first order, and `underrun_o` stays 0.
- **Backpressure:** with `FIFO_AW=2`, no `pix_rd_i`, and one `line_start`, `stb` stops after 4 words. Asserting `pix_rd_i` resumes fetching, and the 5th address is 'hf80010.
- **Retry:** the slave asserts `rty` twice and then `ack` on word 3. Required: address 'hf8000c is issued three times, 160 words are pushed, and `err_o` stays 0. With 4 consecutive `rty`s, a zero word is pushed and `err_o`=1.
- **Late and limit:** `line_start` during FETCH sets `late_o` with no extra fetch. After 480 lines, a further `line_start` is ignored and `cyc` stays 0.
- **Underrun and frame flush:** `pix_rd_i` on an empty FIFO gives `underrun_o`=1 and `pix_o`=0. `frame_start` coincident with an ack gives the word discarded, `pix_vld_o`=0, `wb_adr_o`='hf80000 and flags cleared.
- **Async reset mid-fetch:** `wb_rst_i` low mid-line forces `cyc`/`stb` low immediately, without waiting for a clock edge, and all outputs take their reset values.

Source files
------------

// File: rtl/vcache_linefetch.sv
// ---------------------------------------------------------------------------
// vcache_linefetch
//
// Scanline prefetcher for the VGA output path. On each line request it reads
// WORDS_PER_LINE 32-bit words from VRAM over a Wishbone classic read master
// into a FIFO. It then hands pixels to the timing generator one at a time,
// unpacking each head word LSB-first. A frame pulse flushes everything and
// rewinds the address to VRAM_ADR_BASE.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-low reset
//   frame_start_i             vblank pulse: abort, flush, rewind, clear flags
//   line_start_i              request the next scanline fetch
//   pix_rd_i                  consume one pixel
//   pix_o / pix_vld_o         head pixel (0 when empty) / FIFO non-empty
//   wb_cyc_o .. wb_dat_o      Wishbone master outputs (read-only master)
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_rty_i        Wishbone slave responses
//   busy_o                    in FETCH state
//   underrun_o, late_o, err_o sticky status, cleared by frame_start_i
// ---------------------------------------------------------------------------
module vcache_linefetch #(
    parameter logic [31:0] VRAM_ADR_BASE  = 32'h00f8_0000,
    parameter int          WORDS_PER_LINE = 160,
    parameter int          LINES          = 480,
    parameter int          PIX_W          = 8,   // 8, 16 or 32
    parameter int          FIFO_AW        = 8,
    parameter int          MAX_RETRY      = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             frame_start_i,
    input  logic             line_start_i,
    input  logic             pix_rd_i,
    output logic [PIX_W-1:0] pix_o,
    output logic             pix_vld_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [31:0]      wb_adr_o,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    output logic             busy_o,
    output logic             underrun_o,
    output logic             late_o,
    output logic             err_o
);

    localparam int PPW    = 32 / PIX_W;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int WCW    = $clog2(WORDS_PER_LINE + 1);
    localparam int LCW    = $clog2(LINES + 1);
    localparam int RCW    = $clog2(MAX_RETRY + 2);
    localparam int CW     = FIFO_AW + 1;
    localparam int DEPTH  = 2 ** FIFO_AW;

    localparam logic [WCW-1:0]    WORD_LAST = WCW'(WORDS_PER_LINE - 1);
    localparam logic [LCW-1:0]    LINE_MAX  = LCW'(LINES);
    localparam logic [RCW-1:0]    RETRY_MAX = RCW'(MAX_RETRY);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPW - 1);
    localparam logic [CW-1:0]     FIFO_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RETRY = 2'd2
    } state_t;

    state_t              state_q;
    logic                cyc_q;
    logic [31:0]         adr_q;
    logic [WCW-1:0]      word_cnt_q;
    logic [LCW-1:0]      line_cnt_q;
    logic [RCW-1:0]      retry_cnt_q;
    logic                underrun_q, late_q, err_q;

    logic [31:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LANE_W-1:0]   lane_q;

    // -----------------------------------------------------------------------
    // Termination decode. Only one termination is honoured per cycle, in the
    // order ack > err > rty. An rty that arrives after MAX_RETRY reissues
    // behaves like err: a zero word is pushed and the address moves on.
    // -----------------------------------------------------------------------
    logic in_fetch, ack_hit, err_hit, rty_hit, rty_exh, push, rd_fire, pop;
    logic [31:0] push_data;
    logic        room_d;

    assign in_fetch = (state_q == FETCH) && cyc_q;
    assign ack_hit  = in_fetch && wb_ack_i;
    assign err_hit  = in_fetch && !wb_ack_i && wb_err_i;
    assign rty_hit  = in_fetch && !wb_ack_i && !wb_err_i && wb_rty_i;
    assign rty_exh  = rty_hit && (retry_cnt_q >= RETRY_MAX);

    // A frame pulse discards any coincident termination and any coincident read.
    assign push      = !frame_start_i && (ack_hit || err_hit || rty_exh);
    assign push_data = ack_hit ? wb_dat_i : 32'h0;

    assign pix_vld_o = (cnt_q != '0);
    assign rd_fire   = !frame_start_i && pix_rd_i && pix_vld_o;
    assign pop       = rd_fire && (lane_q == LANE_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!push && pop)
            cnt_d = cnt_q - 1'b1;
    end

    // Strobe is only raised if the word it fetches is guaranteed a slot.
    // The check uses the post-edge occupancy, so a held strobe never
    // targets a full FIFO.
    assign room_d = (cnt_d < FIFO_FULL);

    // -----------------------------------------------------------------------
    // Fetch FSM, address/counter bookkeeping and sticky flags
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= VRAM_ADR_BASE;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            retry_cnt_q <= '0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (frame_start_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= VRAM_ADR_BASE;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            retry_cnt_q <= '0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (pix_rd_i && !pix_vld_o)
                underrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    // Requests beyond the last line of the frame are dropped silently.
                    if (line_start_i && (line_cnt_q < LINE_MAX)) begin
                        state_q    <= FETCH;
                        word_cnt_q <= '0;
                        cyc_q      <= room_d;
                    end
                end

                FETCH: begin
                    if (line_start_i)
                        late_q <= 1'b1;
                    if (push) begin
                        // The address keeps running across lines; the next line
                        // starts where this one ended.
                        adr_q       <= adr_q + 32'd4;
                        retry_cnt_q <= '0;
                        if (!ack_hit)
                            err_q <= 1'b1;
                        if (word_cnt_q == WORD_LAST) begin
                            state_q    <= IDLE;
                            cyc_q      <= 1'b0;
                            line_cnt_q <= line_cnt_q + 1'b1;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            cyc_q      <= room_d;
                        end
                    end else if (rty_hit) begin
                        state_q     <= RETRY;
                        cyc_q       <= 1'b0;
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                    end else if (!cyc_q) begin
                        cyc_q <= room_d;
                    end
                end

                RETRY: begin
                    if (line_start_i)
                        late_q <= 1'b1;
                    state_q <= FETCH;
                    cyc_q   <= room_d;
                end

                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, occupancy and pixel lane
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
        end else if (frame_start_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) begin
                if (lane_q == LANE_LAST) begin
                    lane_q   <= '0;
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end else begin
                    lane_q <= lane_q + 1'b1;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= push_data;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic [31:0] head_w;
    assign head_w = mem_q[rd_ptr_q];

    always_comb begin
        pix_o = '0;
        if (pix_vld_o)
            pix_o = head_w[int'(lane_q)*PIX_W +: PIX_W];
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_adr_o   = adr_q;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = 4'b1111;
    assign wb_dat_o   = 32'h0;
    assign busy_o     = (state_q == FETCH);
    assign underrun_o = underrun_q;
    assign late_o     = late_q;
    assign err_o      = err_q;

endmodule
